// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The fetch FSM encoding and the PC increment live here so the top and the bench agree on them.
package fetch_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with push/pop/flush, gated by a global enable.
// The head is read combinationally and forced to zero while the buffer is empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Occupancy is the only full/empty source; a pop in the same cycle frees room for a push.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_en && !i_flush && w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order fetch front end: one outstanding memory request feeding a prefetch queue,
// with redirect support that squashes any response still in flight at the time of the clear.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = INST_W,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   i_clear,
  input  logic [XLEN-1:0]        i_new_pc,
  output logic                   o_mem_req,
  output logic [XLEN-1:0]        o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic                   i_mem_valid,
  input  logic [XLEN-1:0]        i_mem_data,
  output logic                   o_out_valid,
  output logic [XLEN-1:0]        o_out_inst,
  output logic [XLEN-1:0]        o_out_pc,
  input  logic                   i_out_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_req_pc;
  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_head;
  logic              w_below_full;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  assign w_below_full = (w_count < CW'(DEPTH));
  assign w_accept     = (r_state == REQ) && i_mem_ack;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  // An ack coincident with a clear still counts as accepted, so its response must be dropped.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (!i_clear && w_below_full) w_state_next = REQ;
      REQ: begin
        if (i_mem_ack)    w_state_next = i_clear ? DROP : WAIT;
        else if (i_clear) w_state_next = IDLE;
      end
      WAIT: begin
        if (i_mem_valid)  w_state_next = IDLE;
        else if (i_clear) w_state_next = DROP;
      end
      DROP: if (i_mem_valid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_mem_req = (r_state == REQ) && !i_clear;
    w_push    = (r_state == WAIT) && i_mem_valid && !i_clear;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (rdy_in) begin
      if (i_clear) begin
        r_fetch_pc <= i_new_pc;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      end
      if (w_accept) r_req_pc <= r_fetch_pc;
    end
  end

  assign o_mem_addr  = r_fetch_pc;
  assign o_out_valid = (w_count != '0) && !i_clear;
  assign w_pop       = o_out_valid && i_out_ready;

  fetch_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_en       (rdy_in),
    .i_push     (w_push),
    .i_push_data({r_req_pc, i_mem_data}),
    .i_pop      (w_pop),
    .i_flush    (i_clear),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  assign o_out_pc   = w_head[2*XLEN-1:XLEN];
  assign o_out_inst = w_head[XLEN-1:0];
  assign o_count    = w_count;

endmodule
